pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter sequencer for the 13-bit core. Sits directly upstream of the hardware call/return stack: drives its d/push/pop, consumes its q.
- Accepts one decoded flow op per cycle from the execute stage: next, skip, goto, call, return, retfie. Produces the fetch address and a fetch-kill pulse for discarded instructions.
- Tracks stack depth and flags overflow/underflow. Optionally vectors interrupts.

Parameters:
PC_WIDTH, 13, width of pc, target, stack_d, stack_q
STACK_DEPTH_LOG2, 3, log2 of stack entries; must match the stack instance
RESET_VECTOR, 13'h0000, pc value after reset
IRQ_VECTOR, 13'h0004, interrupt entry address (IRQ_EN only)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
op_valid  in  1  flow op presented this cycle
op_code  in  3  0 NEXT, 1 SKIP, 2 GOTO, 3 CALL, 4 RETURN, 5 RETFIE, 6-7 treated as NEXT
target  in  PC_WIDTH  goto/call destination
stall  in  1  pipeline hold
op_ready  out  1  op accepted this cycle = (state==RUN) && !stall
pc  out  PC_WIDTH  current fetch address
fetch_kill  out  1  registered pulse: discard the instruction fetched at the previous pc
stack_d  out  PC_WIDTH  return address to push
stack_push  out  1  registered one-cycle push pulse
stack_pop  out  1  registered one-cycle pop pulse
stack_q  in  PC_WIDTH  stack top; valid one cycle after the pop pulse is sampled
overflow  out  1  sticky: call/irq with stack full
underflow  out  1  sticky: return with stack empty
irq  in  1  level interrupt request (IRQ_EN only)

Behaviour:
- Reset (synchronous, active-high; clock clk): pc=RESET_VECTOR, state=RUN. fetch_kill, stack_push, stack_pop, overflow, underflow = 0. stack_d=0, depth=0, gie=1. Reset mid-return aborts to RUN. The stack shares the same reset.
- States: RUN, RET_POP, RET_LOAD.
- RUN, no op accepted (op_valid=0 or stall=1): pc holds; all pulses 0.
- RUN, op accepted:
  - NEXT: pc<=pc+1.
  - SKIP: pc<=pc+1, fetch_kill<=1.
  - GOTO: pc<=target, fetch_kill<=1.
  - CALL: stack_d<=pc, stack_push<=1, pc<=target, fetch_kill<=1, depth<=depth+1.
  - RETURN or RETFIE: stack_pop<=1, fetch_kill<=1, depth<=depth-1, state<=RET_POP. RETFIE also sets gie<=1.
- RET_POP: stack_pop<=0, state<=RET_LOAD; pc holds.
- RET_LOAD: pc<=stack_q, fetch_kill<=1, state<=RUN.
- stall is ignored in RET_POP and RET_LOAD; a return always completes in 3 cycles and the pop never repeats.
- Pulses are exactly one cycle wide and deassert on the following edge.
- pc arithmetic wraps modulo 2^PC_WIDTH (all-ones +1 -> 0).
- Depth range is 0..2^STACK_DEPTH_LOG2, held in a counter of STACK_DEPTH_LOG2+1 bits.
- CALL at depth=max: push still issued, depth holds at max, overflow<=1.
- RETURN at depth=0: pop still issued, depth holds 0, underflow<=1.
- Flags clear only on reset.
- push and pop are never asserted together.

Optional Feature:
- Macro: PC_SEQUENCER_IRQ_EN.
- Defined:
  - irq port present; internal gie bit.
  - In RUN with !stall, gie=1 and irq=1: treated as a CALL to IRQ_VECTOR with stack_d<=pc, fetch_kill<=1, gie<=0. Any op_valid that cycle is not accepted (op_ready=0).
  - RETFIE restores gie=1.
- Undefined:
  - irq port and gie absent.
  - RETFIE behaves exactly as RETURN.
  - op_ready ignores irq.

Decomposition:
- Package pc_sequencer_pkg holds:
  - op_code enum flow_op_t (NEXT..RETFIE)
  - state enum seq_state_t
  - localparam STACK_ENTRIES = 1<<STACK_DEPTH_LOG2
- One sub-module: stack_depth_tracker (inc/dec counter with saturation and sticky overflow/underflow). Everything else stays flat.

Test Plan:
- Reset then 3 NEXT ops -> pc = 0,1,2,3; no pulses; op_ready=1 throughout.
- At pc=0x010, CALL target=0x123 -> next cycle pc=0x123, stack_d=0x010, stack_push=1, fetch_kill=1; depth=1.
- RETURN with stack top 0x010 -> stack_pop=1 on cycle+1, op_ready=0 for 2 cycles, pc=0x010 on cycle+3 with fetch_kill=1, single pop observed.
- 9 nested CALLs (depth 3) -> overflow=1 after the 9th, depth=8; then RETURN from depth 0 after reset -> underflow=1.
- pc=0x1FFF, NEXT -> pc=0x0000. Then stall=1 with op_valid GOTO 0x055 -> pc holds, no kill; release stall -> pc=0x055.
- PC_SEQUENCER_IRQ_EN: irq=1 at pc=0x020 -> pc=0x004, stack_d=0x020, gie=0; second irq ignored; RETFIE -> pc=0x020, gie=1.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared types and sizing for the program-counter sequencer.
package pc_sequencer_pkg;

  localparam int DEFAULT_STACK_DEPTH_LOG2 = 3;
  localparam int STACK_ENTRIES = 1 << DEFAULT_STACK_DEPTH_LOG2;

  typedef enum logic [2:0] {
    OP_NEXT   = 3'd0,
    OP_SKIP   = 3'd1,
    OP_GOTO   = 3'd2,
    OP_CALL   = 3'd3,
    OP_RETURN = 3'd4,
    OP_RETFIE = 3'd5
  } flow_op_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_RET_POP,
    ST_RET_LOAD
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_stack_depth_tracker.sv
// Saturating call-stack depth counter with sticky overflow/underflow flags.
module stack_depth_tracker
  import pc_sequencer_pkg::*;
#(
  parameter int ENTRIES = STACK_ENTRIES
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic overflow,
  output logic underflow
);

  localparam int W = $clog2(ENTRIES) + 1;
  localparam logic [W-1:0] MAX_DEPTH = W'(ENTRIES);

  logic [W-1:0] depth;

  // Depth saturates at both ends; the caller still issues the push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (inc) begin
      if (depth == MAX_DEPTH) overflow <= 1'b1;
      else                    depth    <= depth + 1'b1;
    end else if (dec) begin
      if (depth == '0) underflow <= 1'b1;
      else             depth     <= depth - 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer driving the hardware call/return stack.
// Optional interrupt vectoring is enabled by defining PC_SEQUENCER_IRQ_EN.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_WIDTH         = 13,
  parameter int STACK_DEPTH_LOG2 = DEFAULT_STACK_DEPTH_LOG2,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [PC_WIDTH-1:0] IRQ_VECTOR   = PC_WIDTH'(4)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                op_valid,
  input  logic [2:0]          op_code,
  input  logic [PC_WIDTH-1:0] target,
  input  logic                stall,
`ifdef PC_SEQUENCER_IRQ_EN
  input  logic                irq,
`endif
  output logic                op_ready,
  output logic [PC_WIDTH-1:0] pc,
  output logic                fetch_kill,
  output logic [PC_WIDTH-1:0] stack_d,
  output logic                stack_push,
  output logic                stack_pop,
  input  logic [PC_WIDTH-1:0] stack_q,
  output logic                overflow,
  output logic                underflow
);

  seq_state_t state;
  flow_op_t   op;
  logic       irq_take;
  logic       op_accept;
  logic       depth_inc;
  logic       depth_dec;

  assign op = flow_op_t'(op_code);

`ifdef PC_SEQUENCER_IRQ_EN
  logic gie;
  assign irq_take = (state == ST_RUN) && !stall && gie && irq;
`else
  assign irq_take = 1'b0;
`endif

  assign op_ready  = (state == ST_RUN) && !stall && !irq_take;
  assign op_accept = op_ready && op_valid;
  assign depth_inc = irq_take || (op_accept && op == OP_CALL);
  assign depth_dec = op_accept && (op == OP_RETURN || op == OP_RETFIE);

  // A return takes three cycles: issue the pop, let the stack settle, load its top.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RUN;
      pc         <= RESET_VECTOR;
      stack_d    <= '0;
      fetch_kill <= 1'b0;
      stack_push <= 1'b0;
      stack_pop  <= 1'b0;
`ifdef PC_SEQUENCER_IRQ_EN
      gie        <= 1'b1;
`endif
    end else begin
      fetch_kill <= 1'b0;
      stack_push <= 1'b0;
      stack_pop  <= 1'b0;
      unique case (state)
        ST_RUN: begin
          if (irq_take) begin
            stack_d    <= pc;
            stack_push <= 1'b1;
            pc         <= IRQ_VECTOR;
            fetch_kill <= 1'b1;
`ifdef PC_SEQUENCER_IRQ_EN
            gie        <= 1'b0;
`endif
          end else if (op_accept) begin
            case (op)
              OP_SKIP: begin
                pc         <= pc + 1'b1;
                fetch_kill <= 1'b1;
              end
              OP_GOTO: begin
                pc         <= target;
                fetch_kill <= 1'b1;
              end
              OP_CALL: begin
                stack_d    <= pc;
                stack_push <= 1'b1;
                pc         <= target;
                fetch_kill <= 1'b1;
              end
              OP_RETURN, OP_RETFIE: begin
                stack_pop  <= 1'b1;
                fetch_kill <= 1'b1;
                state      <= ST_RET_POP;
`ifdef PC_SEQUENCER_IRQ_EN
                if (op == OP_RETFIE) gie <= 1'b1;
`endif
              end
              default: pc <= pc + 1'b1;
            endcase
          end
        end
        ST_RET_POP: state <= ST_RET_LOAD;
        ST_RET_LOAD: begin
          pc         <= stack_q;
          fetch_kill <= 1'b1;
          state      <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  stack_depth_tracker #(
    .ENTRIES(1 << STACK_DEPTH_LOG2)
  ) u_depth (
    .clk      (clk),
    .reset    (reset),
    .inc      (depth_inc),
    .dec      (depth_dec),
    .overflow (overflow),
    .underflow(underflow)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized ops
// against a behavioural model; IRQ scenario runs when PC_SEQUENCER_IRQ_EN is defined.
`timescale 1ns/1ps
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int PW     = 13;
  localparam int PC_MOD = 1 << PW;

  logic          clk = 1'b0;
  logic          reset;
  logic          op_valid;
  logic [2:0]    op_code;
  logic [PW-1:0] target;
  logic          stall;
  logic          irq;
  logic          op_ready;
  logic [PW-1:0] pc;
  logic          fetch_kill;
  logic [PW-1:0] stack_d;
  logic          stack_push;
  logic          stack_pop;
  logic [PW-1:0] stack_q;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  // Behavioural model: return addresses as a plain list, depth as an integer.
  int m_pc;
  int m_ret[$];
  int m_depth;
  bit m_ovf;
  bit m_unf;

  logic [PW-1:0] env_stack[$];

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_code   (op_code),
    .target    (target),
    .stall     (stall),
`ifdef PC_SEQUENCER_IRQ_EN
    .irq       (irq),
`endif
    .op_ready  (op_ready),
    .pc        (pc),
    .fetch_kill(fetch_kill),
    .stack_d   (stack_d),
    .stack_push(stack_push),
    .stack_pop (stack_pop),
    .stack_q   (stack_q),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Environment stack: reacts to the sampled push/pop pulses like the real one.
  always @(posedge clk) begin
    if (reset) begin
      env_stack.delete();
      stack_q <= '0;
    end else begin
      checks++;
      if (stack_push && stack_pop) begin
        errors++;
        $display("[TB] FAIL push_pop_exclusive push=%0b pop=%0b required not both high", stack_push, stack_pop);
      end
      if (stack_push) env_stack.push_back(stack_d);
      if (stack_pop) stack_q <= (env_stack.size() > 0) ? env_stack.pop_back() : '0;
    end
  end

  task automatic do_reset();
    reset    = 1'b1;
    op_valid = 1'b0;
    op_code  = 3'd0;
    target   = '0;
    stall    = 1'b0;
    irq      = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_pc = 0;
    m_ret.delete();
    m_depth = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic drive_cycle(input bit v, input int opc, input int tgt, input bit stl, output bit rdy);
    op_valid = v;
    op_code  = 3'(opc);
    target   = PW'(tgt);
    stall    = stl;
    #1 rdy = op_ready;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    stall    = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pc !== 13'h0000) begin
      errors++; $display("[TB] FAIL reset_pc got=%h want=0000", pc);
    end
    checks++;
    if ({fetch_kill, stack_push, stack_pop, overflow, underflow} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_flags got=%b want=00000", {fetch_kill, stack_push, stack_pop, overflow, underflow});
    end
    checks++;
    if (stack_d !== 13'h0000 || op_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_d_ready got d=%h rdy=%b want d=0000 rdy=1", stack_d, op_ready);
    end
  endtask

  task automatic test_next();
    bit rdy;
    for (int i = 1; i <= 3; i++) begin
      drive_cycle(1'b1, 0, 0, 1'b0, rdy);
      checks++;
      if (rdy !== 1'b1 || pc !== PW'(i) || {fetch_kill, stack_push, stack_pop} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL next_step%0d got rdy=%b pc=%h pulses=%b want rdy=1 pc=%h pulses=000",
                 i, rdy, pc, {fetch_kill, stack_push, stack_pop}, PW'(i));
      end
    end
  endtask

  task automatic test_call_return();
    bit rdy;
    drive_cycle(1'b1, 2, 'h010, 1'b0, rdy);
    checks++;
    if (pc !== 13'h010 || fetch_kill !== 1'b1) begin
      errors++; $display("[TB] FAIL goto got pc=%h kill=%b want pc=010 kill=1", pc, fetch_kill);
    end
    drive_cycle(1'b1, 3, 'h123, 1'b0, rdy);
    checks++;
    if (pc !== 13'h123 || stack_d !== 13'h010 || stack_push !== 1'b1 || fetch_kill !== 1'b1) begin
      errors++;
      $display("[TB] FAIL call got pc=%h d=%h push=%b kill=%b want pc=123 d=010 push=1 kill=1",
               pc, stack_d, stack_push, fetch_kill);
    end
    drive_cycle(1'b1, 4, 0, 1'b0, rdy);
    checks++;
    if (rdy !== 1'b1 || {stack_pop, fetch_kill, op_ready} !== 3'b110 || pc !== 13'h123) begin
      errors++;
      $display("[TB] FAIL ret_issue got rdy=%b pop/kill/ready=%b pc=%h want 1 110 123",
               rdy, {stack_pop, fetch_kill, op_ready}, pc);
    end
    drive_cycle(1'b1, 2, 'h777, 1'b1, rdy);
    checks++;
    if (rdy !== 1'b0 || {stack_pop, fetch_kill, op_ready} !== 3'b000 || pc !== 13'h123) begin
      errors++;
      $display("[TB] FAIL ret_wait got rdy=%b pop/kill/ready=%b pc=%h want 0 000 123",
               rdy, {stack_pop, fetch_kill, op_ready}, pc);
    end
    drive_cycle(1'b0, 0, 0, 1'b0, rdy);
    checks++;
    if (pc !== 13'h010 || {stack_pop, fetch_kill, op_ready} !== 3'b011) begin
      errors++;
      $display("[TB] FAIL ret_load got pc=%h pop/kill/ready=%b want pc=010 011",
               pc, {stack_pop, fetch_kill, op_ready});
    end
  endtask

  task automatic test_overflow_underflow();
    bit rdy;
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      drive_cycle(1'b1, 3, i * 16, 1'b0, rdy);
      if (i == 8) begin
        checks++;
        if (overflow !== 1'b0) begin
          errors++; $display("[TB] FAIL overflow_early got=%b want=0 after 8 calls", overflow);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1 || stack_push !== 1'b1 || pc !== 13'h090) begin
      errors++;
      $display("[TB] FAIL overflow_9th got ovf=%b push=%b pc=%h want ovf=1 push=1 pc=090", overflow, stack_push, pc);
    end
    do_reset();
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("[TB] FAIL overflow_clear got=%b want=0", overflow);
    end
    drive_cycle(1'b1, 4, 0, 1'b0, rdy);
    checks++;
    if (stack_pop !== 1'b1) begin
      errors++; $display("[TB] FAIL underflow_pop got pop=%b want=1", stack_pop);
    end
    repeat (2) drive_cycle(1'b0, 0, 0, 1'b0, rdy);
    checks++;
    if (underflow !== 1'b1 || overflow !== 1'b0 || op_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL underflow got unf=%b ovf=%b rdy=%b want 1 0 1", underflow, overflow, op_ready);
    end
  endtask

  task automatic test_wrap_stall();
    bit rdy;
    do_reset();
    drive_cycle(1'b1, 2, 'h1FFF, 1'b0, rdy);
    drive_cycle(1'b1, 0, 0, 1'b0, rdy);
    checks++;
    if (pc !== 13'h0000 || fetch_kill !== 1'b0) begin
      errors++; $display("[TB] FAIL pc_wrap got pc=%h kill=%b want 0000 0", pc, fetch_kill);
    end
    drive_cycle(1'b1, 2, 'h055, 1'b1, rdy);
    checks++;
    if (rdy !== 1'b0 || pc !== 13'h0000 || fetch_kill !== 1'b0) begin
      errors++; $display("[TB] FAIL stall_hold got rdy=%b pc=%h kill=%b want 0 0000 0", rdy, pc, fetch_kill);
    end
    drive_cycle(1'b1, 2, 'h055, 1'b0, rdy);
    checks++;
    if (rdy !== 1'b1 || pc !== 13'h055 || fetch_kill !== 1'b1) begin
      errors++; $display("[TB] FAIL stall_release got rdy=%b pc=%h kill=%b want 1 0055 1", rdy, pc, fetch_kill);
    end
  endtask

  task automatic test_random();
    bit rdy, v, stl, ok;
    int opc, tgt, prev, ret_pc;
    do_reset();
    for (int i = 0; i < 150; i++) begin
      opc  = $urandom_range(0, 7);
      tgt  = $urandom_range(0, PC_MOD - 1);
      v    = ($urandom_range(0, 4) != 0);
      stl  = ($urandom_range(0, 3) == 0);
      prev = m_pc;
      drive_cycle(v, opc, tgt, stl, rdy);
      checks++;
      if (rdy !== !stl) begin
        errors++; $display("[TB] FAIL rnd_ready iter=%0d got=%b want=%b", i, rdy, !stl);
      end
      if (!v || stl) begin
        checks++;
        if (pc !== PW'(prev) || {fetch_kill, stack_push, stack_pop} !== 3'b000) begin
          errors++;
          $display("[TB] FAIL rnd_idle iter=%0d got pc=%h pulses=%b want pc=%h pulses=000",
                   i, pc, {fetch_kill, stack_push, stack_pop}, PW'(prev));
        end
      end else if (opc == 4 || opc == 5) begin
        if (m_depth == 0) m_unf = 1'b1;
        else              m_depth--;
        ret_pc = (m_ret.size() > 0) ? m_ret.pop_back() : 0;
        checks++;
        if (pc !== PW'(prev) || {stack_pop, fetch_kill, stack_push} !== 3'b110) begin
          errors++;
          $display("[TB] FAIL rnd_ret_issue iter=%0d got pc=%h pop/kill/push=%b want pc=%h 110",
                   i, pc, {stack_pop, fetch_kill, stack_push}, PW'(prev));
        end
        ok = 1'b1;
        for (int c = 0; c < 2; c++) begin
          drive_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, PC_MOD - 1),
                      $urandom_range(0, 1) == 1, rdy);
          if (rdy !== 1'b0 || stack_pop !== 1'b0 || stack_push !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (!ok || pc !== PW'(ret_pc) || fetch_kill !== 1'b1) begin
          errors++;
          $display("[TB] FAIL rnd_ret_load iter=%0d got pc=%h kill=%b seq_ok=%b want pc=%h kill=1 seq_ok=1",
                   i, pc, fetch_kill, ok, PW'(ret_pc));
        end
        m_pc = ret_pc;
      end else begin
        bit exp_kill, exp_push;
        exp_kill = (opc == 1 || opc == 2 || opc == 3);
        exp_push = (opc == 3);
        if (opc == 2) m_pc = tgt;
        else if (opc == 3) begin
          if (m_depth == STACK_ENTRIES) m_ovf = 1'b1;
          else                          m_depth++;
          m_ret.push_back(prev);
          m_pc = tgt;
        end else m_pc = (prev + 1) % PC_MOD;
        checks++;
        if (pc !== PW'(m_pc) || fetch_kill !== exp_kill || stack_push !== exp_push || stack_pop !== 1'b0) begin
          errors++;
          $display("[TB] FAIL rnd_op iter=%0d op=%0d got pc=%h kill=%b push=%b pop=%b want pc=%h kill=%b push=%b pop=0",
                   i, opc, pc, fetch_kill, stack_push, stack_pop, PW'(m_pc), exp_kill, exp_push);
        end
        if (exp_push) begin
          checks++;
          if (stack_d !== PW'(prev)) begin
            errors++; $display("[TB] FAIL rnd_call_d iter=%0d got=%h want=%h", i, stack_d, PW'(prev));
          end
        end
      end
      checks++;
      if (overflow !== m_ovf || underflow !== m_unf) begin
        errors++;
        $display("[TB] FAIL rnd_flags iter=%0d got ovf=%b unf=%b want ovf=%b unf=%b", i, overflow, underflow, m_ovf, m_unf);
      end
    end
  endtask

`ifdef PC_SEQUENCER_IRQ_EN
  task automatic test_irq();
    bit rdy;
    do_reset();
    drive_cycle(1'b1, 2, 'h020, 1'b0, rdy);
    irq = 1'b1;
    drive_cycle(1'b1, 0, 0, 1'b0, rdy);
    checks++;
    if (rdy !== 1'b0 || pc !== 13'h004 || stack_d !== 13'h020 || stack_push !== 1'b1 || fetch_kill !== 1'b1) begin
      errors++;
      $display("[TB] FAIL irq_entry got rdy=%b pc=%h d=%h push=%b kill=%b want 0 004 020 1 1",
               rdy, pc, stack_d, stack_push, fetch_kill);
    end
    drive_cycle(1'b1, 0, 0, 1'b0, rdy);
    checks++;
    if (rdy !== 1'b1 || pc !== 13'h005 || stack_push !== 1'b0) begin
      errors++; $display("[TB] FAIL irq_masked got rdy=%b pc=%h push=%b want 1 005 0", rdy, pc, stack_push);
    end
    irq = 1'b0;
    drive_cycle(1'b1, 5, 0, 1'b0, rdy);
    repeat (2) drive_cycle(1'b0, 0, 0, 1'b0, rdy);
    checks++;
    if (pc !== 13'h020 || fetch_kill !== 1'b1) begin
      errors++; $display("[TB] FAIL retfie got pc=%h kill=%b want 020 1", pc, fetch_kill);
    end
    irq = 1'b1;
    drive_cycle(1'b1, 0, 0, 1'b0, rdy);
    irq = 1'b0;
    checks++;
    if (rdy !== 1'b0 || pc !== 13'h004 || stack_d !== 13'h020) begin
      errors++; $display("[TB] FAIL irq_reenabled got rdy=%b pc=%h d=%h want 0 004 020", rdy, pc, stack_d);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_next();
    test_call_return();
    test_overflow_underflow();
    test_wrap_stall();
    test_random();
`ifdef PC_SEQUENCER_IRQ_EN
    test_irq();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
